// File: rtl/vector_fu_if.sv
// rtl/vector_fu_if.sv - read-side capture and write-side result handshake bundle for vector_fu
//
// Purpose: carries the tile memory read-out vector and start strobe into the
// unit, and carries the result vector with its write_en/write_rdy handshake
// and status back out.
//
// Signals:
//   on_off      start strobe from the memory
//   r_data_in   [2*num_inputs+1] x width: A lanes, B lanes, config word
//   write_en    result vector valid toward the consumer
//   write_rdy   consumer accepts the result this cycle
//   w_data_out  [num_inputs] x width result vector
//   busy        unit is not idle
//   done        one-cycle pulse after a completed transfer
//
// Modports: master = memory/consumer side, slave = vector_fu.
interface vector_fu_if #(
  parameter int width      = 16,
  parameter int num_inputs = 4
);
  logic             on_off;
  logic [width-1:0] r_data_in [2*num_inputs+1];
  logic             write_en;
  logic             write_rdy;
  logic [width-1:0] w_data_out [num_inputs];
  logic             busy;
  logic             done;

  modport master (
    output on_off, r_data_in, write_rdy,
    input  write_en, w_data_out, busy, done
  );

  modport slave (
    input  on_off, r_data_in, write_rdy,
    output write_en, w_data_out, busy, done
  );
endinterface

// File: rtl/vector_fu.sv
// rtl/vector_fu.sv - lane-serial vector ALU between a tile memory read port and a write port
//
// Purpose: on a start strobe, captures two operand vectors and a config word,
// computes one lane per cycle through a single shared ALU/multiplier, then
// presents the result vector until the consumer accepts it.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    vector_fu_if.slave (on_off, r_data_in, write_rdy in;
//          write_en, w_data_out, busy, done out)
module vector_fu #(
  parameter int width      = 16,
  parameter int num_inputs = 4
) (
  input  logic       clk,
  input  logic       reset,
  vector_fu_if.slave bus
);
  localparam int total_inputs = 2 * num_inputs;
  localparam int lane_w       = (num_inputs > 1) ? $clog2(num_inputs) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

  state_t            state;
  state_t            state_next;
  logic [lane_w-1:0] lane;
  logic [width-1:0]  op_a   [num_inputs];
  logic [width-1:0]  op_b   [num_inputs];
  logic [width-1:0]  result [num_inputs];
  logic [2:0]        opcode;
  logic              done_q;

  logic              capture;
  logic              transfer;
  logic              last_lane;
  logic [width-1:0]  lane_a;
  logic [width-1:0]  lane_b;
  logic [width-1:0]  alu_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    transfer   = 1'b0;
    last_lane  = (lane == lane_w'(num_inputs - 1));
    case (state)
      IDLE: begin
        if (bus.on_off) begin
          capture    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (last_lane) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (bus.write_rdy) begin
          transfer   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single shared ALU: the operands of the current lane are muxed in.
  // Only the opcode bits of the config word are kept; the rest never matter.
  always_comb begin
    lane_a  = op_a[lane];
    lane_b  = op_b[lane];
    alu_out = lane_a;
    case (opcode)
      3'd0: alu_out = lane_a + lane_b;
      3'd1: alu_out = lane_a - lane_b;
      3'd2: alu_out = lane_a * lane_b;  // self-determined width keeps the low bits
      3'd3: alu_out = lane_a & lane_b;
      3'd4: alu_out = lane_a | lane_b;
      3'd5: alu_out = lane_a ^ lane_b;
      3'd6: alu_out = ($signed(lane_a) > $signed(lane_b)) ? lane_a : lane_b;
      default: alu_out = lane_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane   <= '0;
      opcode <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < num_inputs; i++) begin
        op_a[i]   <= '0;
        op_b[i]   <= '0;
        result[i] <= '0;
      end
    end else begin
      done_q <= transfer;
      if (capture) begin
        lane   <= '0;
        opcode <= bus.r_data_in[total_inputs][2:0];
        for (int i = 0; i < num_inputs; i++) begin
          op_a[i] <= bus.r_data_in[i];
          op_b[i] <= bus.r_data_in[num_inputs + i];
        end
      end else if (state == EXEC) begin
        result[lane] <= alu_out;
        // Explicit wrap so non-power-of-two lane counts restart at zero.
        lane <= last_lane ? '0 : lane + 1'b1;
      end
    end
  end

  // write_en follows the state directly, so it is high from the edge that
  // enters OUT and drops on the edge of the transfer.
  always_comb begin
    bus.write_en = (state == OUT);
    bus.busy     = (state != IDLE);
    bus.done     = done_q;
    for (int i = 0; i < num_inputs; i++) begin
      bus.w_data_out[i] = result[i];
    end
  end
endmodule

// File: tb/tb_vector_fu.sv
// tb/tb_vector_fu.sv - randomized self-checking bench for vector_fu against a lane-wise arithmetic model
module tb_vector_fu;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vector_fu_if #(.width(W), .num_inputs(N)) bus ();

  vector_fu #(.width(W), .num_inputs(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] cur_a [N];
  logic [15:0] cur_b [N];
  logic [15:0] cur_cfg;
  logic [15:0] exp_r [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference: each lane computed directly from the opcode table with integer math.
  function automatic logic [15:0] ref_op(input int op, input int a, input int b);
    longint r;
    int sa, sb;
    case (op)
      0: r = a + b;
      1: r = a - b + 65536;
      2: r = longint'(a) * longint'(b);
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: begin
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        r  = (sa > sb) ? a : b;
      end
      default: r = a;
    endcase
    return 16'(r % 65536);
  endfunction

  task automatic compute_exp();
    for (int i = 0; i < N; i++) exp_r[i] = ref_op(int'(cur_cfg) % 8, int'(cur_a[i]), int'(cur_b[i]));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.r_data_in[i]     = cur_a[i];
      bus.r_data_in[N + i] = cur_b[i];
    end
    bus.r_data_in[2*N] = cur_cfg;
  endtask

  task automatic randomize_op();
    for (int i = 0; i < N; i++) begin
      cur_a[i] = 16'($urandom);
      cur_b[i] = 16'($urandom);
    end
    cur_cfg = 16'($urandom);
  endtask

  task automatic set_uniform(input logic [15:0] a, input logic [15:0] b, input logic [15:0] cfg);
    for (int i = 0; i < N; i++) begin
      cur_a[i] = a;
      cur_b[i] = b;
    end
    cur_cfg = cfg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lanes(input string tag);
    for (int i = 0; i < N; i++) check($sformatf("%s[%0d]", tag, i), bus.w_data_out[i], exp_r[i]);
  endtask

  task automatic run_op(input int stall, input bit iso);
    int lat;
    compute_exp();
    drive_inputs();
    bus.write_rdy = (stall == 0);
    bus.on_off    = 1'b1;
    step();
    bus.on_off = 1'b0;
    check("busy_exec", bus.busy, 1);
    lat = 0;
    while (!bus.write_en && lat < 20) begin
      step();
      lat++;
      if (iso && lat == 1) begin
        for (int i = 0; i <= 2*N; i++) bus.r_data_in[i] = 16'h00FF;
        bus.on_off = 1'b1;
      end
      if (iso && lat == 2) bus.on_off = 1'b0;
    end
    check("latency", lat, N);
    for (int s = 0; s < stall; s++) begin
      check("stall_en", bus.write_en, 1);
      check("stall_done", bus.done, 0);
      check_lanes("stall_data");
      step();
    end
    bus.write_rdy = 1'b1;
    check("out_en", bus.write_en, 1);
    check_lanes("out_data");
    step();
    check("xfer_en", bus.write_en, 0);
    check("done", bus.done, 1);
    check("idle_busy", bus.busy, 0);
    check_lanes("kept_data");
    bus.write_rdy = 1'b0;
    step();
    check("done_pulse", bus.done, 0);
    check("still_idle", bus.busy, 0);
  endtask

  task automatic back_to_back(input int ops);
    int lat;
    int last_done;
    last_done = 0;
    bus.write_rdy = 1'b1;
    randomize_op();
    compute_exp();
    drive_inputs();
    bus.on_off = 1'b1;
    step();
    for (int k = 0; k < ops; k++) begin
      lat = 0;
      while (!bus.write_en && lat < 20) begin
        step();
        lat++;
      end
      check("b2b_latency", lat, N);
      check_lanes("b2b_data");
      step();
      check("b2b_done", bus.done, 1);
      check("b2b_done_idle", bus.busy, 0);
      if (k > 0) check("b2b_period", cyc - last_done, N + 2);
      last_done = cyc;
      if (k == ops - 1) begin
        bus.on_off = 1'b0;
      end else begin
        randomize_op();
        compute_exp();
        drive_inputs();
      end
      step();
      check("b2b_capture", bus.busy, (k == ops - 1) ? 0 : 1);
    end
    bus.write_rdy = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.on_off    = 1'b0;
    bus.write_rdy = 1'b0;
    for (int i = 0; i <= 2*N; i++) bus.r_data_in[i] = '0;
    step();
    step();
    check("rst_en", bus.write_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    for (int i = 0; i < N; i++) exp_r[i] = '0;
    check_lanes("rst_data");
    reset = 1'b0;
    step();

    for (int i = 0; i < N; i++) begin
      cur_a[i] = 16'(i + 1);
      cur_b[i] = 16'(i + 10);
    end
    cur_cfg = 16'h0000;
    run_op(0, 1'b0);
    run_op(3, 1'b0);
    run_op(0, 1'b1);

    set_uniform(16'h0000, 16'h0001, 16'h0001);
    run_op(0, 1'b0);
    set_uniform(16'd300, 16'd300, 16'h0002);
    run_op(1, 1'b0);
    set_uniform(16'hFFFF, 16'h0005, 16'h0006);
    run_op(0, 1'b0);
    for (int i = 0; i < N; i++) begin
      cur_a[i] = 16'(i + 1);
      cur_b[i] = 16'(i + 10);
    end
    cur_cfg = 16'hFFF8;
    run_op(2, 1'b0);

    randomize_op();
    drive_inputs();
    bus.write_rdy = 1'b1;
    bus.on_off    = 1'b1;
    step();
    bus.on_off = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_en", bus.write_en, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    for (int i = 0; i < N; i++) exp_r[i] = '0;
    check_lanes("mid_rst_data");
    for (int i = 0; i < 6; i++) step();
    check("mid_rst_quiet", bus.write_en, 0);
    bus.write_rdy = 1'b0;
    randomize_op();
    run_op(1, 1'b0);

    for (int t = 0; t < 16; t++) begin
      randomize_op();
      run_op(int'($urandom_range(0, 3)), 1'b0);
    end

    back_to_back(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vector_fu.md
Name: vector_fu

Overview:
Vector functional unit directly downstream of the tile register memory. When the memory raises its start strobe, the unit captures the full read-out vector: two operand vectors plus one config word. It then executes one lane per cycle through a single shared ALU/multiplier. The result vector goes out over a write_en/write_rdy handshake compatible with a neighbour tile's memory write port.

Parameters:
width, 16, bit width of every data element and of the config word
num_inputs, 4, lanes per operand vector; total_inputs = 2*num_inputs is derived internally

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
on_off  input  1  start strobe, driven by the memory's on_off_vector_fu
r_data_in  input  [width-1:0] x (total_inputs+1)  unpacked array from the memory read port
  - entries 0..num_inputs-1 = operand A lanes
  - entries num_inputs..total_inputs-1 = operand B lanes
  - entry total_inputs = config word
write_en  output  1  result vector valid toward the consumer
write_rdy  input  1  consumer can accept the result this cycle
w_data_out  output  [width-1:0] x num_inputs  result vector, lane i = op(A[i],B[i])
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after a result transfer completes

Behaviour:
- States: IDLE, EXEC, OUT. Lane counter is clog2(num_inputs) bits wide, or 1 bit minimum.
- Reset values: state=IDLE, lane=0, all result registers 0, write_en=0, done=0, busy=0.
- Reset has priority over every other event, including reset asserted mid-EXEC or mid-OUT. The operation is aborted, no write_en is produced and nothing is transferred.
- IDLE: on a rising edge with on_off=1, capture all of r_data_in into internal A/B/config registers, set lane=0 and go to EXEC. With on_off=0, stay in IDLE.
- EXEC: each edge writes result[lane] = op(A[lane],B[lane]) and increments lane. On the edge that writes lane num_inputs-1, go to OUT.
- Latency: if the start is sampled at edge T0, write_en is high from edge T0+num_inputs onward (4 cycles at default).
- Opcode = config[2:0]; config bits above 2 are ignored.
  - 0 ADD, 1 SUB (A-B), 2 MUL (low width bits of the product), 3 AND, 4 OR, 5 XOR, 6 MAX (signed compare), 7 PASS A.
- ADD, SUB and MUL wrap modulo 2^width with no saturation and no flags.
- OUT: write_en=1 and w_data_out is held stable while write_rdy=0, for any number of cycles.
- Transfer occurs on an edge where write_en=1 and write_rdy=1. On the next cycle: state=IDLE, write_en=0, done=1 for exactly one cycle.
- w_data_out keeps its last result after the transfer, until it is overwritten lane-by-lane by the next operation.
- on_off is ignored in EXEC and OUT; there is no queuing.
- on_off=1 in the done cycle (state IDLE) is accepted, giving back-to-back operations.
- After the capture edge, r_data_in changes have no effect on the operation in flight.
- write_rdy is ignored outside OUT.

Test Plan:
- ADD: A={1,2,3,4}, B={10,11,12,13}, config=0, write_rdy=1, pulse on_off for 1 cycle -> write_en rises exactly 4 cycles after the start edge; w_data_out={11,13,15,17}; write_en high 1 cycle; done pulses next cycle; busy low after.
- Wrap and MUL: SUB with A=0, B=1 -> lane=0xFFFF. MUL with A=300, B=300 -> 24464. MAX with A=0xFFFF, B=5 -> 5. config=0xFFF8 (opcode 0) behaves as ADD.
- Backpressure: write_rdy=0 for 3 cycles after write_en rises -> write_en and w_data_out are stable all 3 cycles. Raise write_rdy -> one transfer, then done=1 once.
- Capture isolation: start ADD, change r_data_in to all 0x00FF and pulse on_off again during EXEC -> result still {11,13,15,17}; no second operation; busy falls only after that single transfer.
- Reset mid-op: assert reset during the 2nd EXEC cycle -> next cycle write_en=0, busy=0, done=0, w_data_out all 0. A new start afterwards completes normally.
- Back-to-back: hold on_off=1 continuously with write_rdy=1 -> one operation every num_inputs+2 cycles; each done cycle coincides with the next capture.
